// File: rtl/i2s_rcv_24b2.sv
// i2s_rcv_24b2: two-channel 24-bit I2S receiver producing {left, right} per lrclk frame
module i2s_rcv_24b2 #(
  parameter int DATA_BITS = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lrclk,
  input  logic                   CBrise,
  input  logic                   CBfall,
  input  logic                   inbit,
  output logic [2*DATA_BITS-1:0] sample,
  output logic                   sample_valid,
  output logic                   frame_err
);
  typedef enum logic [2:0] {IDLE, WAIT_L, SKIP_L, CAP_L, WAIT_R, SKIP_R, CAP_R} state_t;
  localparam logic [4:0] LAST = 5'(DATA_BITS - 1);
  state_t                 state_q, state_d;
  logic [4:0]             bit_count_q, bit_count_d;
  logic [DATA_BITS-1:0]   left_q, left_d, right_q, right_d;
  logic [2*DATA_BITS-1:0] sample_q, sample_d;
  logic                   lrclk_q, publish_q, publish_d, frame_err_q, frame_err_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   fall, rise, cb_rise;
  assign fall = lrclk_q & ~lrclk;
  assign rise = ~lrclk_q & lrclk;
  // a CBrise coincident with CBfall still acts as a rise
  assign cb_rise = CBrise | (CBrise & CBfall);
  always_comb begin
    state_d        = state_q;
    bit_count_d    = bit_count_q;
    left_d         = left_q;
    right_d        = right_q;
    publish_d      = 1'b0;
    frame_err_d    = 1'b0;
    sample_valid_d = publish_q;
    sample_d       = publish_q ? {left_q, right_q} : sample_q;
    case (state_q)
      IDLE:   state_d = lrclk ? WAIT_L : IDLE;
      WAIT_L: state_d = fall ? SKIP_L : WAIT_L;
      WAIT_R: state_d = rise ? SKIP_R : WAIT_R;
      default: begin
        // an lrclk edge inside a word means the slot was short; the edge wins over CBrise
        if (fall | rise) begin
          frame_err_d = 1'b1;
          state_d     = fall ? SKIP_L : WAIT_L;
        end else if (cb_rise) begin
          if (state_q == SKIP_L || state_q == SKIP_R) begin
            state_d     = (state_q == SKIP_L) ? CAP_L : CAP_R;
            bit_count_d = LAST;
          end else begin
            left_d      = (state_q == CAP_L) ? {left_q[DATA_BITS-2:0], inbit} : left_q;
            right_d     = (state_q == CAP_R) ? {right_q[DATA_BITS-2:0], inbit} : right_q;
            bit_count_d = bit_count_q - 5'(bit_count_q != '0);
            if (bit_count_q == '0) begin
              state_d   = (state_q == CAP_L) ? WAIT_R : WAIT_L;
              publish_d = (state_q == CAP_R);
            end
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      bit_count_q    <= '0;
      left_q         <= '0;
      right_q        <= '0;
      sample_q       <= '0;
      lrclk_q        <= 1'b0;
      publish_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_count_q    <= bit_count_d;
      left_q         <= left_d;
      right_q        <= right_d;
      sample_q       <= sample_d;
      lrclk_q        <= lrclk;
      publish_q      <= publish_d;
      frame_err_q    <= frame_err_d;
      sample_valid_q <= sample_valid_d;
    end
  end
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_i2s_rcv_24b2.sv
// tb_i2s_rcv_24b2: directed I2S frames with a bench-side transmitter and pulse/word scoreboard
module tb_i2s_rcv_24b2;
  logic clk = 1'b0, rst = 1'b0, lrclk = 1'b0, CBrise = 1'b0, CBfall = 1'b0, inbit = 1'b0;
  logic [47:0] sample;
  logic sample_valid, frame_err;
  int checks = 0, errors = 0, valid_cnt = 0, err_cnt = 0;
  int v0, e0;
  logic [47:0] last_sample = '0;
  logic [47:0] rxq[$];
  logic [47:0] expq[$];
  logic [23:0] l, r;
  always #5 clk = ~clk;
  i2s_rcv_24b2 #(.DATA_BITS(24)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .CBrise(CBrise), .CBfall(CBfall), .inbit(inbit),
    .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (sample_valid) begin
      valid_cnt++;
      last_sample = sample;
      rxq.push_back(sample);
    end
    if (frame_err) err_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one BCLK period: lrclk/data change with the falling strobe, sampled on the rising one
  task automatic send_bclk(input logic lr, input logic d, input int half);
    lrclk = lr;
    inbit = d;
    CBfall = 1'b1;
    tick();
    CBfall = 1'b0;
    repeat (half - 1) tick();
    CBrise = 1'b1;
    tick();
    CBrise = 1'b0;
    repeat (half - 1) tick();
  endtask
  task automatic send_slot(input logic lr, input logic [23:0] w, input int len, input int half);
    send_bclk(lr, ~w[23], half);
    for (int i = 0; i < len - 1; i++) send_bclk(lr, (i < 24) ? w[23 - i] : 1'b0, half);
  endtask
  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int len, input int half);
    send_slot(1'b0, lw, len, half);
    send_slot(1'b1, rw, len, half);
  endtask
  initial begin
    repeat (3) tick();
    check("reset_sample", sample, 48'h0);
    check("reset_valid", {47'h0, sample_valid}, 48'h0);
    check("reset_err", {47'h0, frame_err}, 48'h0);
    // startup mid-left-word: nothing until a full rise then fall
    rst = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) send_bclk(1'b0, 1'b1, 4);
    send_slot(1'b1, 24'h111111, 32, 4);
    check("startup_no_valid", 48'(valid_cnt - v0), 48'd0);
    e0 = err_cnt;
    send_frame(24'hABCDEF, 24'h123456, 32, 4);
    check("startup_first", last_sample, 48'hABCDEF123456);
    send_frame(24'hABCDEF, 24'h123456, 32, 4);
    check("basic32_count", 48'(valid_cnt - v0), 48'd2);
    check("basic32_sample", last_sample, 48'hABCDEF123456);
    check("basic32_no_err", 48'(err_cnt - e0), 48'd0);
    // exact 25-BCLK slots, walking ones
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      send_frame(i[0] ? 24'h000001 : 24'h800000, i[0] ? 24'h800000 : 24'h000001, 25, 4);
      check("exact24", last_sample, i[0] ? 48'h000001800000 : 48'h800000000001);
    end
    check("exact24_count", 48'(valid_cnt - v0), 48'd8);
    check("exact24_no_err", 48'(err_cnt - e0), 48'd0);
    // short left word: error, frame dropped, old sample held
    v0 = valid_cnt;
    e0 = err_cnt;
    send_slot(1'b0, 24'hFFFFFF, 17, 4);
    send_slot(1'b1, 24'h777777, 32, 4);
    check("short_l_err", 48'(err_cnt - e0), 48'd1);
    check("short_l_no_valid", 48'(valid_cnt - v0), 48'd0);
    check("short_l_held", sample, 48'h000001800000);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 32, 4);
    check("short_l_recover", last_sample, 48'h5A5A5AA5A5A5);
    check("short_l_count", 48'(valid_cnt - v0), 48'd1);
    // short right word: fall realigns on the following left word
    v0 = valid_cnt;
    e0 = err_cnt;
    send_slot(1'b0, 24'h13579B, 32, 4);
    send_slot(1'b1, 24'h2468AC, 12, 4);
    send_frame(24'hC0FFEE, 24'h0BADF0, 32, 4);
    check("short_r_err", 48'(err_cnt - e0), 48'd1);
    check("short_r_count", 48'(valid_cnt - v0), 48'd1);
    check("short_r_sample", last_sample, 48'hC0FFEE0BADF0);
    // reset pulse in the middle of the right capture
    v0 = valid_cnt;
    e0 = err_cnt;
    l = 24'h654321;
    send_slot(1'b0, l, 32, 4);
    send_bclk(1'b1, 1'b0, 4);
    for (int i = 0; i < 10; i++) send_bclk(1'b1, l[23 - i], 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_sample", sample, 48'h0);
    check("rst_mid_valid", {47'h0, sample_valid}, 48'h0);
    for (int i = 10; i < 31; i++) send_bclk(1'b1, 1'b1, 4);
    check("rst_mid_no_valid", 48'(valid_cnt - v0), 48'd0);
    send_frame(24'h0F1E2D, 24'h3C4B5A, 32, 4);
    check("rst_mid_recover", last_sample, 48'h0F1E2D3C4B5A);
    check("rst_mid_count", 48'(valid_cnt - v0), 48'd1);
    check("rst_mid_no_err", 48'(err_cnt - e0), 48'd0);
    // random loopback with varying slot length and BCLK ratio
    rxq.delete();
    e0 = err_cnt;
    for (int i = 0; i < 100; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      expq.push_back({l, r});
      send_frame(l, r, int'($urandom_range(25, 32)), int'($urandom_range(1, 3)));
    end
    send_slot(1'b0, 24'h0, 25, 2);
    check("loop_count", 48'(rxq.size()), 48'd100);
    check("loop_no_err", 48'(err_cnt - e0), 48'd0);
    for (int i = 0; i < 100 && i < rxq.size(); i++) check("loop_word", rxq[i], expq[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
